// File: rtl/tx_burst_sched_pkg.sv
// Shared types and helpers for the TX burst scheduler.
package tx_burst_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/tx_burst_sched_skid_buf.sv
// Two-entry valid/ready buffer between the FIFO read port and the TX stream.
module tx_skid_buf #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [1:0]            o_occ
);

    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  r_wr;
    logic                  r_rd;
    logic [1:0]            r_cnt;
    logic                  w_wr;
    logic                  w_rd;

    assign w_wr    = i_valid && (r_cnt != 2'd2);
    assign w_rd    = o_valid && i_ready;
    assign o_valid = (r_cnt != 2'd0);
    assign o_data  = r_mem[r_rd];
    assign o_occ   = r_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr  <= 1'b0;
            r_rd  <= 1'b0;
            r_cnt <= '0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= ~r_wr;
            end
            if (w_rd) begin
                r_rd <= ~r_rd;
            end
            case ({w_wr, w_rd})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/tx_burst_sched.sv
// Drain-side scheduler for the TX sync FIFO: decides burst size and timing,
// arbitrates for the TX link and streams popped words out with a last marker.
module tx_burst_sched
    import tx_burst_sched_pkg::*;
#(
    parameter int unsigned PTR_WIDTH  = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 15,
    parameter int unsigned BURST_LEN  = 8,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  fifo_push,
    input  logic                  fifo_empty,
    output logic                  fifo_pop,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  burst_req,
    input  logic                  burst_gnt,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  busy,
    output logic [PTR_WIDTH:0]    level
);

    localparam int unsigned   LW        = PTR_WIDTH + 1;
    localparam int unsigned   TW        = $clog2(TIMEOUT + 1);
    localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
    localparam logic [LW-1:0] BURST_L   = LW'(BURST_LEN);
    localparam logic [TW-1:0] TIMEOUT_T = TW'(TIMEOUT);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [LW-1:0]   r_level;
    logic [LW-1:0]   r_len;
    logic [LW-1:0]   r_issued;
    logic [LW-1:0]   r_acc;
    logic [TW-1:0]   r_timer;
    logic            r_flush_pend;
    logic            r_pop_d;

    logic [1:0]            w_occ;
    logic                  w_skid_valid;
    logic [DATA_WIDTH-1:0] w_skid_data;
    logic                  w_start;
    logic                  w_level_nz;
    logic                  w_pop_room;
    logic                  w_pop;
    logic                  w_beat_acc;
    logic                  w_last_beat;
    logic                  w_last_acc;
    logic                  w_idle_empty;

    assign w_level_nz   = (r_level != '0);
    assign w_idle_empty = (r_state == ST_IDLE) && !w_level_nz;
    // A pop issued last cycle still owns a skid slot until its data lands.
    assign w_pop_room   = ((w_occ + {1'b0, r_pop_d}) < 2'd2);
    assign w_pop        = (r_state == ST_XFER) && !fifo_push && !fifo_empty &&
                          w_level_nz && (r_issued != r_len) && w_pop_room;
    assign w_beat_acc   = (r_state == ST_XFER) && w_skid_valid && out_ready;
    assign w_last_beat  = (r_state == ST_XFER) && w_skid_valid && ((r_acc + LW'(1)) == r_len);
    assign w_last_acc   = w_last_beat && out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable && ((r_level >= BURST_L) ||
                               (w_level_nz && (r_timer == TIMEOUT_T)) ||
                               (w_level_nz && (flush || r_flush_pend)))) begin
                    w_state_nxt = ST_REQ;
                    w_start     = 1'b1;
                end
            end
            ST_REQ: begin
                if (burst_gnt) begin
                    w_state_nxt = ST_XFER;
                end
            end
            ST_XFER: begin
                if (w_last_acc) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= ST_IDLE;
            r_level      <= '0;
            r_timer      <= '0;
            r_len        <= '0;
            r_issued     <= '0;
            r_acc        <= '0;
            r_flush_pend <= 1'b0;
            r_pop_d      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pop_d <= w_pop;

            if (fifo_push) begin
                if (r_level != DEPTH_L) r_level <= r_level + LW'(1);
            end else if (w_pop) begin
                r_level <= r_level - LW'(1);
            end

            if (w_start || !(r_state == ST_IDLE && enable && w_level_nz)) begin
                r_timer <= '0;
            end else if (r_timer != TIMEOUT_T) begin
                r_timer <= r_timer + TW'(1);
            end

            if (w_start) begin
                r_len    <= LW'(min_u(32'(r_level), BURST_LEN));
                r_issued <= '0;
                r_acc    <= '0;
            end else begin
                if (w_pop)      r_issued <= r_issued + LW'(1);
                if (w_beat_acc) r_acc    <= r_acc + LW'(1);
            end

            // Flush stays armed until a burst leaves the FIFO drained.
            if (flush && !w_idle_empty) begin
                r_flush_pend <= 1'b1;
            end else if (w_idle_empty || (w_last_acc && !w_level_nz)) begin
                r_flush_pend <= 1'b0;
            end
        end
    end

    tx_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rstn    (rstn),
        .i_valid (r_pop_d),
        .i_data  (fifo_dout),
        .i_ready (out_ready),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data),
        .o_occ   (w_occ)
    );

    assign fifo_pop  = w_pop;
    assign burst_req = (r_state == ST_REQ);
    assign busy      = (r_state != ST_IDLE);
    assign out_valid = w_skid_valid;
    assign out_data  = w_skid_data;
    assign out_last  = w_last_beat;
    assign level     = r_level;

endmodule

// File: tb/tb_tx_burst_sched.sv
// Directed bench for tx_burst_sched with a behavioural sync FIFO on the read side.
module tb_tx_burst_sched;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rstn, enable, flush, fifo_push, fifo_empty, fifo_pop;
    logic          burst_req, burst_gnt, out_valid, out_last, out_ready, busy;
    logic [DW-1:0] fifo_dout, out_data, din;
    logic [4:0]    level;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int viol_pp = 0;
    int viol_occ = 0;
    int fcnt;
    logic [DW-1:0] fq[$];
    logic [DW-1:0] beat_d[$];
    logic          beat_l[$];

    always #5 clk = ~clk;

    tx_burst_sched #(
        .PTR_WIDTH(4), .DATA_WIDTH(DW), .DEPTH(15), .BURST_LEN(8), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .flush(flush),
        .fifo_push(fifo_push), .fifo_empty(fifo_empty), .fifo_pop(fifo_pop),
        .fifo_dout(fifo_dout), .burst_req(burst_req), .burst_gnt(burst_gnt),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .busy(busy), .level(level)
    );

    // FIFO model: pop is ignored in a push cycle; read data appears one cycle after pop.
    assign fifo_empty = (fcnt == 0);
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fq.delete();
            fcnt      <= 0;
            fifo_dout <= '0;
        end else if (fifo_push) begin
            fq.push_back(din);
            fcnt <= fcnt + 1;
        end else if (fifo_pop && fq.size() > 0) begin
            fifo_dout <= fq.pop_front();
            fcnt      <= fcnt - 1;
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            if (out_valid && out_ready) begin
                beat_d.push_back(out_data);
                beat_l.push_back(out_last);
            end
            if (fifo_pop && fifo_push) viol_pp++;
            if (fifo_pop && dut.u_skid.o_occ == 2'd2) viol_occ++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_n(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            fifo_push = 1'b1;
            din       = base + DW'(i);
            tick();
        end
        fifo_push = 1'b0;
    endtask

    task automatic wait_req(output int k);
        k = 0;
        while (!burst_req && k < 100) begin
            tick();
            k++;
        end
    endtask

    task automatic grant();
        tick();
        tick();
        burst_gnt = 1'b1;
        tick();
        burst_gnt = 1'b0;
    endtask

    task automatic wait_beats(input int n, input bit toggle);
        int k = 0;
        while (beat_d.size() < n && k < 200) begin
            if (toggle) out_ready = ~out_ready;
            tick();
            k++;
        end
        out_ready = 1'b1;
    endtask

    task automatic chk_burst(input string tag, input int n, input logic [DW-1:0] base);
        chk({tag, "_beats"}, 64'(beat_d.size()), 64'(n));
        for (int i = 0; i < n && i < beat_d.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), 64'(beat_d[i]), 64'(base + DW'(i)));
            chk($sformatf("%s_last%0d", tag, i), 64'(beat_l[i]), 64'(i == n - 1));
        end
        beat_d.delete();
        beat_l.delete();
    endtask

    initial begin
        int k;
        int np;
        rstn = 1'b0; enable = 1'b0; flush = 1'b0; fifo_push = 1'b0;
        burst_gnt = 1'b0; out_ready = 1'b0; din = '0;
        tick();
        tick();
        chk("rst_req",   64'(burst_req), 64'(0));
        chk("rst_pop",   64'(fifo_pop),  64'(0));
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_last",  64'(out_last),  64'(0));
        chk("rst_busy",  64'(busy),      64'(0));
        chk("rst_level", 64'(level),     64'(0));
        chk("rst_data",  64'(out_data),  64'(0));
        rstn = 1'b1;
        out_ready = 1'b1;
        tick();

        // enable=0 holds the scheduler idle even with a full burst buffered
        push_n(8, 32'h100);
        tick(); tick(); tick();
        chk("en0_level", 64'(level), 64'(8));
        chk("en0_noreq", 64'(burst_req), 64'(0));

        // T1: full burst
        enable = 1'b1;
        wait_req(k);
        chk("t1_req_lat", 64'(k), 64'(1));
        chk("t1_busy", 64'(busy), 64'(1));
        grant();
        wait_beats(8, 1'b0);
        tick(); tick();
        chk_burst("t1", 8, 32'h100);
        chk("t1_level", 64'(level), 64'(0));
        chk("t1_busy_end", 64'(busy), 64'(0));

        // T2: timer runs from the first push edge; 16 counting edges, then REQ registers
        // on the next edge -> 15 edges after the third (last) push edge.
        push_n(3, 32'h200);
        wait_req(k);
        chk("t2_timeout", 64'(k), 64'(15));
        grant();
        wait_beats(3, 1'b0);
        tick();
        chk_burst("t2", 3, 32'h200);

        // T3: flush forces an immediate partial burst
        push_n(5, 32'h300);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t3_flush_req", 64'(burst_req), 64'(1));
        grant();
        wait_beats(5, 1'b0);
        tick();
        chk_burst("t3", 5, 32'h300);
        chk("t3_level", 64'(level), 64'(0));
        tick(); tick(); tick();
        chk("t3_no_rereq", 64'(burst_req), 64'(0));

        // T4: backpressure toggling every cycle
        push_n(8, 32'h400);
        wait_req(k);
        chk("t4_req", 64'(burst_req), 64'(1));
        grant();
        wait_beats(8, 1'b1);
        tick();
        chk_burst("t4", 8, 32'h400);
        chk("t4_pop_full", 64'(viol_occ), 64'(0));

        // T5: pushes interleaved with the drain
        push_n(8, 32'h500);
        wait_req(k);
        grant();
        np = 0;
        for (int j = 0; j < 200 && beat_d.size() < 8; j++) begin
            fifo_push = (j % 2 == 0) && (np < 4);
            if (fifo_push) begin
                din = 32'h580 + DW'(np);
                np++;
            end
            tick();
        end
        fifo_push = 1'b0;
        tick();
        chk_burst("t5a", 8, 32'h500);
        chk("t5_level", 64'(level), 64'(4));
        chk("t5_pop_push", 64'(viol_pp), 64'(0));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_flush_req", 64'(burst_req), 64'(1));
        grant();
        wait_beats(4, 1'b0);
        tick();
        chk_burst("t5b", 4, 32'h580);

        // T6: reset in the middle of a burst
        push_n(8, 32'h600);
        wait_req(k);
        grant();
        wait_beats(3, 1'b0);
        rstn = 1'b0;
        #1;
        chk("t6_req",   64'(burst_req), 64'(0));
        chk("t6_busy",  64'(busy),      64'(0));
        chk("t6_pop",   64'(fifo_pop),  64'(0));
        chk("t6_valid", 64'(out_valid), 64'(0));
        chk("t6_last",  64'(out_last),  64'(0));
        chk("t6_level", 64'(level),     64'(0));
        chk("t6_data",  64'(out_data),  64'(0));
        tick();
        rstn = 1'b1;
        beat_d.delete();
        beat_l.delete();
        tick();
        push_n(8, 32'h700);
        wait_req(k);
        chk("t6_req_after", 64'(burst_req), 64'(1));
        grant();
        wait_beats(8, 1'b0);
        tick();
        chk_burst("t6", 8, 32'h700);
        chk("t6_level_end", 64'(level), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
